// File: rtl/write_fifo_drain.sv
// Write FIFO drain: pops {address, data} word pairs and issues one Avalon-MM write per pair.
// Optional address-word check enabled by defining WRITE_DRAIN_ADDR_CHECK_EN.
module write_fifo_drain #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_W    = 23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        FF_empty,
    input  logic [31:0] FF_q,
    output logic        FF_readrequest,
    output logic [31:0] avm_address,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    output logic        avm_write,
    input  logic        avm_waitrequest,
    output logic        wr_done,
    output logic        busy,
    output logic        addr_err
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR_LAT  = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_DATA_LAT  = 3'd3,
        ST_WRITE     = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ADDR_W-1:0]   addr_r;
    logic                pop_s;
    logic                accept_s;
    logic                addr_bad_s;

`ifdef WRITE_DRAIN_ADDR_CHECK_EN
    // Any bit above the word-address field marks the address word as malformed.
    function automatic logic addr_word_bad(input logic [31:0] word);
        return ((word >> ADDR_W) != 32'h0000_0000);
    endfunction
`endif

    assign avm_byteenable = 4'hF;

    // Malformed-address detection while the address word is on FF_q.
`ifdef WRITE_DRAIN_ADDR_CHECK_EN
    always_comb begin
        if (state_r == ST_ADDR_LAT) begin
            addr_bad_s = addr_word_bad(FF_q);
        end else begin
            addr_bad_s = 1'b0;
        end
    end
`else
    always_comb begin
        addr_bad_s = 1'b0;
    end
`endif

    // Next-state, pop request and write-accept decode.
    always_comb begin
        state_nxt_s    = state_r;
        pop_s          = 1'b0;
        accept_s       = 1'b0;
        FF_readrequest = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!FF_empty) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_ADDR_LAT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADDR_LAT: begin
                // A dropped address word returns to IDLE so the next word is again an address.
                if (addr_bad_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (!FF_empty) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_DATA_LAT;
                end else begin
                    state_nxt_s = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (!FF_empty) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_DATA_LAT;
                end else begin
                    state_nxt_s = ST_WAIT_DATA;
                end
            end
            ST_DATA_LAT: begin
                state_nxt_s = ST_WRITE;
            end
            ST_WRITE: begin
                if (!avm_waitrequest) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WRITE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        // No pops while reset is held, so a reset never silently eats a word.
        if (rst) begin
            FF_readrequest = 1'b0;
        end else begin
            FF_readrequest = pop_s;
        end
    end

    // State, address/data capture and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            addr_r        <= '0;
            avm_address   <= 32'h0000_0000;
            avm_writedata <= 32'h0000_0000;
            avm_write     <= 1'b0;
            wr_done       <= 1'b0;
            busy          <= 1'b0;
            addr_err      <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_ADDR_LAT) && !addr_bad_s) begin
                addr_r <= FF_q[ADDR_W-1:0];
            end
            // Command fields load only on entry to WRITE, so they hold through stalls and idle.
            if (state_r == ST_DATA_LAT) begin
                avm_writedata <= FF_q;
                avm_address   <= BASE_ADDR + {{(30-ADDR_W){1'b0}}, addr_r, 2'b00};
            end
            avm_write <= (state_nxt_s == ST_WRITE);
            busy      <= (state_nxt_s != ST_IDLE);
            wr_done   <= accept_s;
            addr_err  <= addr_bad_s;
        end
    end

endmodule

// File: tb/tb_write_fifo_drain.sv
// Bench for write_fifo_drain: FIFO model, pair-level reference queue, directed and random traffic.
module tb_write_fifo_drain;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        FF_empty;
    logic [31:0] FF_q = 32'h0;
    logic        FF_readrequest;
    logic [31:0] avm_address;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_write;
    logic        avm_waitrequest;
    logic        wr_done;
    logic        busy;
    logic        addr_err;

    write_fifo_drain dut (
        .clk(clk), .rst(rst), .FF_empty(FF_empty), .FF_q(FF_q),
        .FF_readrequest(FF_readrequest), .avm_address(avm_address),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_write(avm_write), .avm_waitrequest(avm_waitrequest),
        .wr_done(wr_done), .busy(busy), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: normal mode, one-cycle read latency
    logic [31:0] mem [256];
    logic [7:0]  wr_ptr = 8'd0;
    logic [7:0]  rd_ptr = 8'd0;
    int          pops = 0;
    assign FF_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (FF_readrequest) begin
            FF_q   <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 8'd1;
            pops   <= pops + 1;
        end
    end

    // waitrequest: forced value or random per cycle
    logic wr_mode = 1'b0;
    logic wr_force = 1'b0;
    logic rand_wr = 1'b0;
    assign avm_waitrequest = wr_mode ? rand_wr : wr_force;
    always begin
        @(posedge clk);
        #1;
        rand_wr = ($urandom_range(0, 2) == 0);
    end

    // Reference model: word stream -> expected {address, data} writes
    logic [63:0] exp_q[$];
    logic        want_data = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          drops = 0;

    task automatic model_word(input logic [31:0] w);
        if (!want_data) begin
`ifdef WRITE_DRAIN_ADDR_CHECK_EN
            if (w >= 32'h0080_0000) begin
                drops = drops + 1;
            end else begin
                pend_addr = w;
                want_data = 1'b1;
            end
`else
            pend_addr = w;
            want_data = 1'b1;
`endif
        end else begin
            exp_q.push_back({BASE + (pend_addr % 32'h0080_0000) * 32'd4, w});
            want_data = 1'b0;
        end
    endtask

    task automatic push_raw(input logic [31:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic push(input logic [31:0] w);
        push_raw(w);
        model_word(w);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor state
    logic        prev_acc = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] st_addr = 32'h0;
    logic [31:0] st_data = 32'h0;
    logic [31:0] last_addr = 32'h0;
    logic [31:0] last_data = 32'h0;
    int          acc_cycles[$];
    int          write_cycles = 0;
    int          done_count = 0;
    int          err_count = 0;

    // Per-cycle compare against the reference model, sampled on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            prev_acc   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (FF_readrequest) check("pop_while_empty", {63'd0, FF_empty}, 64'd0);
            check("byteenable", {60'd0, avm_byteenable}, 64'hF);
            check("wr_done_timing", {63'd0, wr_done}, {63'd0, prev_acc});
            if (wr_done) done_count = done_count + 1;
            if (addr_err) err_count = err_count + 1;
            if (prev_stall)
                check("stall_hold", {avm_write, avm_address, avm_writedata},
                      {1'b1, st_addr, st_data});
            if (avm_write) begin
                write_cycles = write_cycles + 1;
                if (!avm_waitrequest) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", {avm_address, avm_writedata}, 64'd0);
                        if ({avm_address, avm_writedata} === 64'd0) begin
                            errors = errors + 1;
                            $display("FAIL unexpected_write: got a write, required none");
                        end
                    end else begin
                        check("write_pair", {avm_address, avm_writedata}, exp_q.pop_front());
                    end
                    last_addr = avm_address;
                    last_data = avm_writedata;
                    acc_cycles.push_back(cyc);
                end
            end
            prev_acc   = avm_write && !avm_waitrequest;
            prev_stall = avm_write && avm_waitrequest;
            st_addr    = avm_address;
            st_data    = avm_writedata;
        end
    end

    task automatic wait_idle(input string name, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            ok = FF_empty && (exp_q.size() == 0) && (busy === want_data) && !avm_write;
        end
        if (!ok) begin
            errors = errors + 1;
            $display("FAIL %s: drain did not complete in %0d cycles, pending=%0d", name, budget,
                     exp_q.size());
        end
        step(1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int p0;
    int w0;
    int d0;
    int e0;
    logic [31:0] a_w;
    initial begin
        mem = '{default: 32'h0};
        step(3);
        @(negedge clk);
        check("rst_outputs", {FF_readrequest, avm_write, wr_done, busy, addr_err, avm_address,
                              avm_writedata}, 64'd0);
        check("rst_byteenable", {60'd0, avm_byteenable}, 64'hF);
        step(1);
        rst = 1'b0;

        // Single pair, no stall
        p0 = pops; w0 = write_cycles; d0 = done_count;
        push(32'h0000_0010);
        push(32'hDEAD_BEEF);
        wait_idle("t1", 40);
        check("t1_addr", {32'd0, last_addr}, 64'h40);
        check("t1_data", {32'd0, last_data}, 64'hDEAD_BEEF);
        check("t1_pops", pops - p0, 64'd2);
        check("t1_write_cycles", write_cycles - w0, 64'd1);
        check("t1_done", done_count - d0, 64'd1);
        check("t1_busy", {63'd0, busy}, 64'd0);

        // Data word arrives late
        p0 = pops;
        push(32'h0000_0100);
        step(5);
        check("t2_wait_pops", pops - p0, 64'd1);
        check("t2_wait_busy", {63'd0, busy}, 64'd1);
        push(32'hCAFE_F00D);
        wait_idle("t2", 40);
        check("t2_addr", {32'd0, last_addr}, 64'h400);
        check("t2_pops", pops - p0, 64'd2);

        // Three stall cycles in WRITE
        w0 = write_cycles; d0 = done_count;
        wr_force = 1'b1;
        push(32'h0000_0020);
        push(32'h1111_2222);
        for (int i = 0; i < 40 && !avm_write; i++) @(negedge clk);
        check("t3_write_seen", {63'd0, avm_write}, 64'd1);
        step(3);
        wr_force = 1'b0;
        wait_idle("t3", 40);
        check("t3_write_cycles", write_cycles - w0, 64'd4);
        check("t3_done", done_count - d0, 64'd1);
        check("t3_addr", {32'd0, last_addr}, 64'h80);

        // Back-to-back pairs
        for (int i = 1; i <= 3; i++) begin
            push(32'(i));
            push(32'hA000_0000 + 32'(i));
        end
        wait_idle("t4", 60);
        check("t4_last_addr", {32'd0, last_addr}, 64'hC);
        check("t4_spacing_a", acc_cycles[$] - acc_cycles[$-1], 64'd4);
        check("t4_spacing_b", acc_cycles[$-1] - acc_cycles[$-2], 64'd4);

        // Random traffic with random stalls and occasional malformed address words
        wr_mode = 1'b1;
        for (int i = 0; i < 240; i++) begin
            a_w = $urandom;
            if (i % 2 == 0) begin
                a_w = a_w & 32'h007F_FFFF;
                if ($urandom_range(0, 7) == 0) a_w = a_w | 32'h0080_0000 | ($urandom & 32'hFF00_0000);
            end
            push(a_w);
            step($urandom_range(0, 3));
        end
        if (want_data) push($urandom);
        wait_idle("random", 3000);
        wr_mode = 1'b0;

        // Reset while in DATA_LAT discards the half-read pair
        p0 = pops;
        push_raw(32'h0000_0033);
        push_raw(32'h7777_7777);
        step(2);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5_rst_outputs", {FF_readrequest, avm_write, wr_done, busy, addr_err, avm_address,
                                 avm_writedata}, 64'd0);
        step(1);
        rst = 1'b0;
        check("t5_pops", pops - p0, 64'd2);
        push(32'h0000_0044);
        push(32'h5555_AAAA);
        wait_idle("t5", 40);
        check("t5_addr", {32'd0, last_addr}, 64'h110);
        check("t5_data", {32'd0, last_data}, 64'h5555_AAAA);

        // Malformed address word
        e0 = err_count;
        push(32'h8000_0001);
        push(32'h0000_0002);
        push(32'h1234_5678);
        wait_idle("t6", 60);
`ifdef WRITE_DRAIN_ADDR_CHECK_EN
        check("t6_err", err_count - e0, 64'd1);
        check("t6_addr", {32'd0, last_addr}, 64'h8);
        check("t6_data", {32'd0, last_data}, 64'h1234_5678);
`else
        check("t6_err", err_count - e0, 64'd0);
        check("t6_addr", {32'd0, last_addr}, 64'h4);
        check("t6_data", {32'd0, last_data}, 64'h2);
        push(32'h0000_0000);
        wait_idle("t6_tail", 40);
`endif
        check("addr_err_total", err_count, drops);
        check("final_queue", exp_q.size(), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
